// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: fetch-to-decode handshake bundle for fetch_buffer.
// master = fetch/decode side driving the buffer, slave = the buffer itself.
interface fetch_buffer_if #(
    parameter int N     = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N-1:0]  imem_addr_F;
    logic [31:0]   instr_F;
    logic          valid_F;
    logic          ready_F;
    logic          flush;
    logic [N-1:0]  pc_D;
    logic [31:0]   instr_D;
    logic          valid_D;
    logic          ready_D;
    logic [CW-1:0] count;

    modport master (
        output imem_addr_F, instr_F, valid_F, flush, ready_D,
        input  ready_F, pc_D, instr_D, valid_D, count
    );

    modport slave (
        input  imem_addr_F, instr_F, valid_F, flush, ready_D,
        output ready_F, pc_D, instr_D, valid_D, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of {PC, instruction} pairs between fetch and decode.
// Flush (taken branch) empties the buffer with top priority. An invalid head
// presents PC 0 and the NOP encoding 32'hD503201F.
// Optional macro FETCH_BUF_BYPASS_EN: when the buffer is empty, the fetch pair is
// forwarded combinationally to decode and, if consumed, never written.
module fetch_buffer #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'hD503201F;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_buffer: DEPTH must be a power of two, at least 2");
    end

    logic [N-1:0]  pc_mem_q    [DEPTH];
    logic [N-1:0]  pc_mem_d    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic head_valid;
    logic bypass;
    logic push;
    logic pop;

    // Handshake decode and decode-side output muxing
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        head_valid = reset & ~empty & ~bus.flush;
`ifdef FETCH_BUF_BYPASS_EN
        bypass     = reset & empty & bus.valid_F & ~bus.flush;
`else
        bypass     = 1'b0;
`endif
        bus.ready_F = reset & ~full;
        bus.valid_D = head_valid | bypass;
        bus.count   = count_q;

        if (head_valid) begin
            bus.pc_D    = pc_mem_q[rd_ptr_q];
            bus.instr_D = instr_mem_q[rd_ptr_q];
        end else if (bypass) begin
            bus.pc_D    = bus.imem_addr_F;
            bus.instr_D = bus.instr_F;
        end else begin
            bus.pc_D    = '0;
            bus.instr_D = NOP;
        end

        // A bypassed pair taken by decode this cycle is not stored
        pop  = head_valid & bus.ready_D;
        push = bus.valid_F & bus.ready_F & ~bus.flush & ~(bypass & bus.ready_D);
    end

    // Next-state: flush clears pointers and count; otherwise push/pop update
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = bus.imem_addr_F;
                instr_mem_d[wr_ptr_q] = bus.instr_F;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer (N=64, DEPTH=4).
// Honours FETCH_BUF_BYPASS_EN in the empty-buffer bypass scenario.
module tb_fetch_buffer;
    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fetch_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

    fetch_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction word tagged with its PC so misordered entries are visible
    function automatic logic [31:0] ins(input logic [N-1:0] pc);
        return 32'hA000_0000 | pc[31:0];
    endfunction

    task automatic drive(input logic v, input logic [N-1:0] pc, input logic [31:0] iw,
                         input logic rd, input logic fl);
        bus.valid_F     = v;
        bus.imem_addr_F = pc;
        bus.instr_F     = iw;
        bus.ready_D     = rd;
        bus.flush       = fl;
    endtask

    // Advance past the next rising edge; outputs settle by the following #1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 64'h55, 32'h1234_5678, 1'b1, 1'b0);
        #1;
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        vectors++; if (bus.valid_D !== 1'b0) begin miscompares++; $display("FAIL reset_valid_D: got %b expected 0", bus.valid_D); end
        vectors++; if (bus.ready_F !== 1'b0) begin miscompares++; $display("FAIL reset_ready_F: got %b expected 0", bus.ready_F); end
        vectors++; if (bus.pc_D !== 64'h0) begin miscompares++; $display("FAIL reset_pc_D: got %h expected 0", bus.pc_D); end
        vectors++; if (bus.instr_D !== NOP) begin miscompares++; $display("FAIL reset_instr_D: got %h expected %h", bus.instr_D, NOP); end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++; if (bus.ready_F !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready_F: got %b expected 1", bus.ready_F); end
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL post_reset_count: got %0d expected 0", bus.count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i), ins(64'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
        vectors++; if (bus.ready_F !== 1'b0) begin miscompares++; $display("FAIL fill_ready_F: got %b expected 0", bus.ready_F); end
        vectors++; if (bus.pc_D !== 64'h0) begin miscompares++; $display("FAIL fill_pc_D: got %h expected 0", bus.pc_D); end
        vectors++; if (bus.instr_D !== ins(64'h0)) begin miscompares++; $display("FAIL fill_instr_D: got %h expected %h", bus.instr_D, ins(64'h0)); end
        drive(1'b1, 64'h10, ins(64'h10), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL overflow_count: got %0d expected 4", bus.count); end
        vectors++; if (bus.pc_D !== 64'h0) begin miscompares++; $display("FAIL overflow_pc_D: got %h expected 0", bus.pc_D); end
    endtask

    task automatic test_full_pop();
        drive(1'b1, 64'h10, ins(64'h10), 1'b1, 1'b0);
        #1;
        vectors++; if (bus.ready_F !== 1'b0) begin miscompares++; $display("FAIL full_pop_ready_F: got %b expected 0", bus.ready_F); end
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL full_pop_count: got %0d expected 3", bus.count); end
        vectors++; if (bus.pc_D !== 64'h4) begin miscompares++; $display("FAIL full_pop_pc_D: got %h expected 4", bus.pc_D); end
        vectors++; if (bus.instr_D !== ins(64'h4)) begin miscompares++; $display("FAIL full_pop_instr_D: got %h expected %h", bus.instr_D, ins(64'h4)); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("FAIL b2b_start_count: got %0d expected 2", bus.count); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(16 + 4 * i), ins(64'(16 + 4 * i)), 1'b1, 1'b0);
            #1;
            vectors++; if (bus.pc_D !== 64'(8 + 4 * i)) begin miscompares++; $display("FAIL b2b_pc_D[%0d]: got %h expected %h", i, bus.pc_D, 64'(8 + 4 * i)); end
            vectors++; if (bus.instr_D !== ins(64'(8 + 4 * i))) begin miscompares++; $display("FAIL b2b_instr_D[%0d]: got %h expected %h", i, bus.instr_D, ins(64'(8 + 4 * i))); end
            vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, bus.count); end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("FAIL b2b_end_count: got %0d expected 2", bus.count); end
        vectors++; if (bus.pc_D !== 64'h28) begin miscompares++; $display("FAIL b2b_end_pc_D: got %h expected 28", bus.pc_D); end
    endtask

    task automatic test_flush();
        drive(1'b1, 64'h30, ins(64'h30), 1'b0, 1'b0);
        tick();
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL flush_pre_count: got %0d expected 3", bus.count); end
        drive(1'b1, 64'h40, ins(64'h40), 1'b1, 1'b1);
        #1;
        vectors++; if (bus.valid_D !== 1'b0) begin miscompares++; $display("FAIL flush_valid_D: got %b expected 0", bus.valid_D); end
        vectors++; if (bus.pc_D !== 64'h0) begin miscompares++; $display("FAIL flush_pc_D: got %h expected 0", bus.pc_D); end
        vectors++; if (bus.instr_D !== NOP) begin miscompares++; $display("FAIL flush_instr_D: got %h expected %h", bus.instr_D, NOP); end
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
        vectors++; if (bus.valid_D !== 1'b0) begin miscompares++; $display("FAIL flush_after_valid_D: got %b expected 0", bus.valid_D); end
        vectors++; if (bus.pc_D !== 64'h0) begin miscompares++; $display("FAIL flush_after_pc_D: got %h expected 0", bus.pc_D); end
        tick();
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL flush_idle_count: got %0d expected 0", bus.count); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 64'h100, 32'h8B020020, 1'b1, 1'b0);
        #1;
`ifdef FETCH_BUF_BYPASS_EN
        vectors++; if (bus.valid_D !== 1'b1) begin miscompares++; $display("FAIL bypass_valid_D: got %b expected 1", bus.valid_D); end
        vectors++; if (bus.pc_D !== 64'h100) begin miscompares++; $display("FAIL bypass_pc_D: got %h expected 100", bus.pc_D); end
        vectors++; if (bus.instr_D !== 32'h8B020020) begin miscompares++; $display("FAIL bypass_instr_D: got %h expected 8b020020", bus.instr_D); end
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL bypass_count: got %0d expected 0", bus.count); end
        vectors++; if (bus.valid_D !== 1'b0) begin miscompares++; $display("FAIL bypass_after_valid_D: got %b expected 0", bus.valid_D); end
`else
        vectors++; if (bus.valid_D !== 1'b0) begin miscompares++; $display("FAIL latency_same_cycle_valid_D: got %b expected 0", bus.valid_D); end
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL latency_count: got %0d expected 1", bus.count); end
        vectors++; if (bus.valid_D !== 1'b1) begin miscompares++; $display("FAIL latency_valid_D: got %b expected 1", bus.valid_D); end
        vectors++; if (bus.pc_D !== 64'h100) begin miscompares++; $display("FAIL latency_pc_D: got %h expected 100", bus.pc_D); end
        vectors++; if (bus.instr_D !== 32'h8B020020) begin miscompares++; $display("FAIL latency_instr_D: got %h expected 8b020020", bus.instr_D); end
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL latency_drain_count: got %0d expected 0", bus.count); end
`endif
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 64'h200, ins(64'h200), 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h204, ins(64'h204), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("FAIL mid_pre_count: got %0d expected 2", bus.count); end
        reset = 1'b0;
        #1;
        vectors++; if (bus.valid_D !== 1'b0) begin miscompares++; $display("FAIL mid_valid_D: got %b expected 0", bus.valid_D); end
        vectors++; if (bus.instr_D !== NOP) begin miscompares++; $display("FAIL mid_instr_D: got %h expected %h", bus.instr_D, NOP); end
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL mid_count: got %0d expected 0", bus.count); end
        vectors++; if (bus.ready_F !== 1'b0) begin miscompares++; $display("FAIL mid_ready_F: got %b expected 0", bus.ready_F); end
        tick();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        vectors++; if (bus.ready_F !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready_F: got %b expected 1", bus.ready_F); end
        vectors++; if (bus.valid_D !== 1'b0) begin miscompares++; $display("FAIL mid_release_valid_D: got %b expected 0", bus.valid_D); end
        drive(1'b1, 64'h300, ins(64'h300), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL mid_repush_count: got %0d expected 1", bus.count); end
        vectors++; if (bus.pc_D !== 64'h300) begin miscompares++; $display("FAIL mid_repush_pc_D: got %h expected 300", bus.pc_D); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_full_pop();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
